comp_v_int_serial: RTL
======================

// Module: comp_v_int_serial
// PURPOSE
// Slice-serial, parametrised successor to the single-shot integer residual stage of the online divider.
// Forms v = w - q in plus/minus (redundant) form over UPPER_WIDTH integer bits, CHUNK bits per cycle.
// Then compares (v_plus - v_minus) against +/-THRESH to emit the next signed quotient digit.
// Sits between the residual register and the digit-selection/append logic. Start/busy/done handshake.
// PARAMETERS
// UPPER_WIDTH  6  integer-part width of w, q, v (must be a multiple of CHUNK, >= 2)
// CHUNK        2  bits added per cycle; NSLICE = UPPER_WIDTH/CHUNK
// THRESH       1  digit-selection threshold, unsigned, < 2^(UPPER_WIDTH-1)
// PORTS
// clk                 in   1            clock, all state on rising edge
// asyn_reset          in   1            reset, synchronous, active-high
// start               in   1            request; sampled only in IDLE
// w_plus_int          in   UPPER_WIDTH  residual, positive vector
// w_minus_int         in   UPPER_WIDTH  residual, negative vector
// q_plus_int          in   UPPER_WIDTH  quotient term, positive vector
// q_minus_int         in   UPPER_WIDTH  quotient term, negative vector
// cin_one             in   1            carry-in, plus-side adder (slice 0)
// cin_two             in   1            carry-in, minus-side adder (slice 0)
// busy                out  1            high from cycle after accepted start until done
// done                out  1            one-cycle pulse, results valid
// v_plus_int          out  UPPER_WIDTH  (w_plus + q_minus + cin_one) mod 2^UPPER_WIDTH
// v_minus_int         out  UPPER_WIDTH  (w_minus + q_plus + cin_two) mod 2^UPPER_WIDTH
// cout_one, cout_two  out  1            carry-out of the plus / minus adder
// digit_plus          out  1            +1 digit flag
// digit_minus         out  1            -1 digit flag (never both high)
// v_zero              out  1            (v_plus_int - v_minus_int) == 0
// BEHAVIOUR
// - Reset: state IDLE, slice counter 0, all outputs and internal regs 0.
// - FSM IDLE -> ADD -> CMP -> IDLE. IDLE & start: capture all inputs, go ADD, busy=1.
// - ADD: slice k (k=0..NSLICE-1, LSB first) adds CHUNK bits of both sums; carries held in regs,
//   seeded from cin_one/cin_two at capture. After slice NSLICE-1 -> CMP, final carries -> cout_*.
// - CMP: d = v_plus_int - v_minus_int, two's complement, UPPER_WIDTH bits, wraps.
//   d >= THRESH -> digit +1 (10); d < -THRESH -> digit -1 (01); else 0 (00). v_zero = (d==0).
//   Assert done for exactly this cycle, busy falls same edge, return to IDLE.
// - Latency: start sampled at edge 0 -> done high in cycle NSLICE+1 (no macro).
// - Back-to-back: start may be high in the cycle after done; accepted normally.
// - start while busy: ignored, no effect on captured operands.
// - Outputs hold last result until next done; v_* partial bits visible during ADD are don't-care.
// - Reset mid-operation: abort, everything to reset values next edge, no done.
// - Adders are modular; overflow only reported via cout_*; never saturate.
// CONFIGURATION
// COMP_V_INT_OUT_REG_EN defined: extra output register stage after CMP; done, digit_*, v_zero, v_*,
//   cout_* delayed one cycle (latency NSLICE+2); busy stays high through that cycle.
// Not defined: results driven directly from CMP state regs, latency NSLICE+1.
// TESTING (UPPER_WIDTH=8, CHUNK=4, THRESH=1, macro off unless stated)
// - w_plus=05, q_plus=02, others 0, cins 0 -> done in cycle 3: v_plus=05, v_minus=02, digit 10, v_zero=0.
// - w_plus=0F, q_minus=01 -> carry across slice: v_plus=10, v_minus=00, cout_one=0, digit 10.
// - w_minus=04, rest 0 -> v_plus=00, v_minus=04, d=-4, digit 01; w_minus=01 -> d=-1, digit 00; all 0 -> v_zero=1.
// - w_plus=FF, q_minus=01, cin_one=0 -> v_plus=00, cout_one=1, d=0, digit 00, v_zero=1.
// - start held high during busy, operands changed -> one done, original result; reset asserted in ADD -> no done, all outputs 0.
// - COMP_V_INT_OUT_REG_EN defined, vector 1 -> identical results, done in cycle 4.

Source files
------------

// File: rtl/comp_v_int_serial.sv
// comp_v_int_serial: slice-serial integer residual stage of the online divider.
// Forms v = w - q in redundant (plus/minus) form, CHUNK bits per cycle, LSB
// slice first. Once the sums are complete, it compares (v_plus - v_minus)
// against +/-THRESH to select the next signed quotient digit.
// Optional build macro COMP_V_INT_OUT_REG_EN adds one output register stage
// after the compare. This raises latency from NSLICE+1 to NSLICE+2 cycles.
module comp_v_int_serial #(
  parameter int UPPER_WIDTH = 6,
  parameter int CHUNK       = 2,
  parameter int THRESH      = 1
) (
  input  logic                   clk,
  input  logic                   asyn_reset,
  input  logic                   start,
  input  logic [UPPER_WIDTH-1:0] w_plus_int,
  input  logic [UPPER_WIDTH-1:0] w_minus_int,
  input  logic [UPPER_WIDTH-1:0] q_plus_int,
  input  logic [UPPER_WIDTH-1:0] q_minus_int,
  input  logic                   cin_one,
  input  logic                   cin_two,
  output logic                   busy,
  output logic                   done,
  output logic [UPPER_WIDTH-1:0] v_plus_int,
  output logic [UPPER_WIDTH-1:0] v_minus_int,
  output logic                   cout_one,
  output logic                   cout_two,
  output logic                   digit_plus,
  output logic                   digit_minus,
  output logic                   v_zero
);

  localparam int W      = UPPER_WIDTH;
  localparam int NSLICE = UPPER_WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [CW-1:0]       LAST_SLICE = CW'(NSLICE - 1);
  localparam logic signed [W-1:0] THR_POS    = W'(THRESH);
  localparam logic signed [W-1:0] THR_NEG    = -THR_POS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_CMP  = 2'd2,
    S_OREG = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Captured operands. They shift right one chunk per slice, so the active
  // slice always sits in the low CHUNK bits.
  logic [W-1:0]    wp_q, wm_q, qp_q, qm_q;
  logic            c1_q, c2_q;
  logic [W-1:0]    accp_q, accm_q;
  logic [CW-1:0]   slice_q;

  // Registered results that drive the outputs. They hold until the next done.
  logic [W-1:0]    vp_out_q, vm_out_q;
  logic            co1_out_q, co2_out_q;
  logic            dp_out_q, dm_out_q, vz_out_q;
  logic            done_q;

`ifdef COMP_V_INT_OUT_REG_EN
  logic [W-1:0]    vp_pipe_q, vm_pipe_q;
  logic            co1_pipe_q, co2_pipe_q;
  logic            dp_pipe_q, dm_pipe_q, vz_pipe_q;
`endif

  // Datapath helpers: one slice of each adder, plus the digit compare.
  logic [CHUNK:0]        sum_p, sum_m;
  logic [W+CHUNK-1:0]    accp_ext, accm_ext;
  logic [W-1:0]          accp_next, accm_next;
  logic signed [W-1:0]   diff;
  logic                  cmp_plus, cmp_minus, cmp_zero;

  // Slice adders and the digit compare (pure combinational).
  always_comb begin
    sum_p     = {1'b0, wp_q[CHUNK-1:0]} + {1'b0, qm_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c1_q};
    sum_m     = {1'b0, wm_q[CHUNK-1:0]} + {1'b0, qp_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c2_q};
    // New slice enters at the top. After NSLICE shifts, slice 0 lands at the LSBs.
    accp_ext  = {sum_p[CHUNK-1:0], accp_q};
    accm_ext  = {sum_m[CHUNK-1:0], accm_q};
    accp_next = accp_ext[W+CHUNK-1:CHUNK];
    accm_next = accm_ext[W+CHUNK-1:CHUNK];
    diff      = accp_q - accm_q;
    cmp_plus  = (diff >= THR_POS);
    cmp_minus = (diff <  THR_NEG);
    cmp_zero  = (diff == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (asyn_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic: IDLE -> ADD (NSLICE cycles) -> CMP [-> OREG] -> IDLE.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_ADD;
      S_ADD:  if (slice_q == LAST_SLICE) state_d = S_CMP;
`ifdef COMP_V_INT_OUT_REG_EN
      S_CMP:  state_d = S_OREG;
`else
      S_CMP:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers every non-idle state.
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Datapath: capture operands, accumulate slices, register the results.
  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      wp_q      <= '0;
      wm_q      <= '0;
      qp_q      <= '0;
      qm_q      <= '0;
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
      accp_q    <= '0;
      accm_q    <= '0;
      slice_q   <= '0;
      vp_out_q  <= '0;
      vm_out_q  <= '0;
      co1_out_q <= 1'b0;
      co2_out_q <= 1'b0;
      dp_out_q  <= 1'b0;
      dm_out_q  <= 1'b0;
      vz_out_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef COMP_V_INT_OUT_REG_EN
      vp_pipe_q  <= '0;
      vm_pipe_q  <= '0;
      co1_pipe_q <= 1'b0;
      co2_pipe_q <= 1'b0;
      dp_pipe_q  <= 1'b0;
      dm_pipe_q  <= 1'b0;
      vz_pipe_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            wp_q    <= w_plus_int;
            wm_q    <= w_minus_int;
            qp_q    <= q_plus_int;
            qm_q    <= q_minus_int;
            c1_q    <= cin_one;
            c2_q    <= cin_two;
            accp_q  <= '0;
            accm_q  <= '0;
            slice_q <= '0;
          end
        end
        S_ADD: begin
          accp_q  <= accp_next;
          accm_q  <= accm_next;
          c1_q    <= sum_p[CHUNK];
          c2_q    <= sum_m[CHUNK];
          wp_q    <= wp_q >> CHUNK;
          wm_q    <= wm_q >> CHUNK;
          qp_q    <= qp_q >> CHUNK;
          qm_q    <= qm_q >> CHUNK;
          slice_q <= slice_q + CW'(1);
        end
        S_CMP: begin
`ifdef COMP_V_INT_OUT_REG_EN
          vp_pipe_q  <= accp_q;
          vm_pipe_q  <= accm_q;
          co1_pipe_q <= c1_q;
          co2_pipe_q <= c2_q;
          dp_pipe_q  <= cmp_plus;
          dm_pipe_q  <= cmp_minus;
          vz_pipe_q  <= cmp_zero;
`else
          vp_out_q  <= accp_q;
          vm_out_q  <= accm_q;
          co1_out_q <= c1_q;
          co2_out_q <= c2_q;
          dp_out_q  <= cmp_plus;
          dm_out_q  <= cmp_minus;
          vz_out_q  <= cmp_zero;
          done_q    <= 1'b1;
`endif
        end
        S_OREG: begin
`ifdef COMP_V_INT_OUT_REG_EN
          vp_out_q  <= vp_pipe_q;
          vm_out_q  <= vm_pipe_q;
          co1_out_q <= co1_pipe_q;
          co2_out_q <= co2_pipe_q;
          dp_out_q  <= dp_pipe_q;
          dm_out_q  <= dm_pipe_q;
          vz_out_q  <= vz_pipe_q;
          done_q    <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign done        = done_q;
  assign v_plus_int  = vp_out_q;
  assign v_minus_int = vm_out_q;
  assign cout_one    = co1_out_q;
  assign cout_two    = co2_out_q;
  assign digit_plus  = dp_out_q;
  assign digit_minus = dm_out_q;
  assign v_zero      = vz_out_q;

endmodule
